// File: rtl/smsdac_mse_param.sv
// Segmented mismatch-shaping DAC encoder: cascaded 3-level segments with
// per-segment shaping state, external or LFSR dither, registered outputs.
module smsdac_mse_param #(
    parameter int          NSEG       = 7,
    parameter int          DITHER_INT = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              en,
    input  logic              clr,
    input  logic [1:0]        mode,
    input  logic [NSEG-1:0]   x,
    input  logic              x_c,
    input  logic [NSEG-1:0]   r,
    output logic [2*NSEG-1:0] y,
    output logic              y_c,
    output logic              out_valid
);

    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] POS  = 2'b01;
    localparam logic [1:0] NEG  = 2'b10;

    logic [2*NSEG-1:0] q;
    logic [2*NSEG-1:0] q_nxt;
    logic [2*NSEG-1:0] y_nxt;
    logic [NSEG:0]     c;
    logic [NSEG-1:0]   d;
    logic [15:0]       lfsr;
    logic              fb;
    logic              shape;

    assign d     = (DITHER_INT != 0) ? lfsr[NSEG-1:0] : r;
    assign fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign shape = (mode == 2'b00);

    // Ripple carry chain; a clr in the same cycle makes every segment see q=0.
    always_comb begin
        logic [1:0] qk;
        logic [1:0] s;
        logic [1:0] yk;
        logic       up;
        qk    = ZERO;
        s     = 2'd0;
        yk    = ZERO;
        up    = 1'b1;
        c     = '0;
        c[0]  = x_c;
        y_nxt = '0;
        q_nxt = '0;
        for (int k = 0; k < NSEG; k++) begin
            qk = clr ? ZERO : q[2*k +: 2];
            s  = {1'b0, x[k]} + {1'b0, c[k]};
            unique case (1'b1)
                mode[1]:           up = 1'b1;
                (mode == 2'b01):   up = d[k];
                default:           up = (qk == ZERO) ? d[k] : (qk == NEG);
            endcase
            case (s)
                2'd0: begin
                    yk       = ZERO;
                    c[k+1]   = 1'b0;
                end
                2'd1: begin
                    yk       = up ? POS : NEG;
                    c[k+1]   = ~up;
                end
                default: begin
                    yk       = ZERO;
                    c[k+1]   = 1'b1;
                end
            endcase
            y_nxt[2*k +: 2] = yk;
            if (!shape)
                q_nxt[2*k +: 2] = ZERO;
            else if (qk == ZERO)
                q_nxt[2*k +: 2] = yk;
            else if (yk == ZERO)
                q_nxt[2*k +: 2] = qk;
            else
                q_nxt[2*k +: 2] = ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q         <= '0;
            lfsr      <= LFSR_SEED;
            y         <= '0;
            y_c       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (en) begin
                y    <= y_nxt;
                y_c  <= c[NSEG];
                lfsr <= {fb, lfsr[15:1]};
            end
            if (clr)
                q <= '0;
            else if (en)
                q <= q_nxt;
        end
    end

endmodule

// File: tb/tb_smsdac_mse_param.sv
// Bench for smsdac_mse_param: reference model feeds an expected-output
// queue, each scenario task pops and compares the registered outputs.
module tb_smsdac_mse_param;

    localparam int N = 7;

    typedef struct {
        logic [2*N-1:0] y;
        logic           yc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_b = 1'b1;
    logic           en = 1'b0;
    logic           clr = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [N-1:0]   x = '0;
    logic           x_c = 1'b0;
    logic [N-1:0]   r = '0;
    logic [2*N-1:0] y;
    logic           y_c;
    logic           out_valid;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    exp_t  last_e;
    int    qm[N];
    logic [15:0] lfsr_m = 16'hACE1;

    smsdac_mse_param #(
        .NSEG(N),
        .DITHER_INT(0),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .en(en),
        .clr(clr),
        .mode(mode),
        .x(x),
        .x_c(x_c),
        .r(r),
        .y(y),
        .y_c(y_c),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [2*N-1:0] yv, input logic ycv);
        int acc;
        acc = ycv ? (1 << N) : 0;
        for (int k = 0; k < N; k++) begin
            if (yv[2*k +: 2] == 2'b01) acc += (1 << k);
            if (yv[2*k +: 2] == 2'b10) acc -= (1 << k);
        end
        return acc;
    endfunction

    function automatic logic [2*N-1:0] q_enc();
        logic [2*N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++)
            v[2*k +: 2] = (qm[k] > 0) ? 2'b01 : (qm[k] < 0) ? 2'b10 : 2'b00;
        return v;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic bit q_bad();
        bit b;
        b = 1'b0;
        for (int k = 0; k < N; k++)
            if (dut.q[2*k +: 2] == 2'b11) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) qm[k] = 0;
        exp_q.delete();
        last_e.y  = '0;
        last_e.yc = 1'b0;
        lfsr_m    = 16'hACE1;
    endtask

    // Drives one cycle of inputs and queues the model's expected output.
    task automatic drive(input logic [N-1:0] xv, input logic xcv,
                         input logic [N-1:0] rv, input logic [1:0] mv,
                         input logic env, input logic clrv);
        exp_t e;
        int   c, s, qv, yk;
        bit   up;
        @(negedge clk);
        x = xv; x_c = xcv; r = rv; mode = mv; en = env; clr = clrv;
        if (env) begin
            c = int'(xcv);
            for (int k = 0; k < N; k++) begin
                s  = int'(xv[k]) + c;
                qv = clrv ? 0 : qm[k];
                if (s == 1) begin
                    if (mv[1])           up = 1'b1;
                    else if (mv[0])      up = rv[k];
                    else if (qv == 0)    up = rv[k];
                    else                 up = (qv < 0);
                    yk = up ? 1 : -1;
                    c  = up ? 0 : 1;
                end else begin
                    yk = 0;
                    c  = s / 2;
                end
                e.y[2*k +: 2] = (yk == 1) ? 2'b01 : (yk == -1) ? 2'b10 : 2'b00;
                qm[k] = (mv == 2'b00) ? qv + yk : 0;
            end
            e.yc = (c != 0);
            exp_q.push_back(e);
            lfsr_m = lfsr_next(lfsr_m);
        end
        if (clrv)
            for (int k = 0; k < N; k++) qm[k] = 0;
    endtask

    task automatic test_reset();
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if (y !== '0 || y_c !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async y=%h y_c=%b ov=%b want 0 0 0", y, y_c, out_valid);
        end
        @(negedge clk);
        en = 1'b1; x = 7'h01;
        @(posedge clk); #1;
        checks++;
        if (y !== '0 || out_valid !== 1'b0 || dut.q !== '0 || dut.lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_hold y=%h ov=%b q=%h lfsr=%h want 0 0 0 ace1",
                     y, out_valid, dut.q, dut.lfsr);
        end
        @(negedge clk);
        en = 1'b0;
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_shape();
        logic [7:0] lo_seq;
        exp_t e;
        lo_seq = 8'b10_01_10_01;
        for (int i = 0; i < 4; i++) begin
            drive(7'h01, 1'b0, 7'h7F, 2'b00, 1'b1, 1'b0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            last_e = e;
            checks++;
            if (y !== e.y || y_c !== e.yc || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL shape_sb[%0d] y=%b y_c=%b ov=%b want %b %b 1",
                         i, y, y_c, out_valid, e.y, e.yc);
            end
            checks++;
            if (y[1:0] !== lo_seq[2*i +: 2] || decode(y, y_c) != 1) begin
                errors++;
                $display("FAIL shape_seg0[%0d] y0=%b sum=%0d want %b 1",
                         i, y[1:0], decode(y, y_c), lo_seq[2*i +: 2]);
            end
            if (i == 1 || i == 3) begin
                checks++;
                if (y[3:2] !== ((i == 1) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL shape_seg1[%0d] y1=%b want %b",
                             i, y[3:2], (i == 1) ? 2'b01 : 2'b10);
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(7'h01, 1'b0, 7'h7F, 2'b00, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        last_e = e;
        checks++;
        if (y !== e.y || y_c !== e.yc || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_pre y=%b y_c=%b want %b %b", y, y_c, e.y, e.yc);
        end
        for (int i = 0; i < 3; i++) begin
            drive(7'(i * 37 + 5), 1'b1, 7'h2A, 2'b00, 1'b0, 1'b0);
            @(posedge clk); #1;
            checks++;
            if (y !== last_e.y || y_c !== last_e.yc || out_valid !== 1'b0 ||
                dut.q !== q_enc() || dut.lfsr !== lfsr_m) begin
                errors++;
                $display("FAIL hold[%0d] y=%b ov=%b q=%h lfsr=%h want %b 0 %h %h",
                         i, y, out_valid, dut.q, dut.lfsr, last_e.y, q_enc(), lfsr_m);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(7'h01, 1'b0, 7'h7F, 2'b00, 1'b1, 1'b0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            last_e = e;
            checks++;
            if (y !== e.y || y_c !== e.yc || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_resume[%0d] y=%b y_c=%b want %b %b",
                         i, y, y_c, e.y, e.yc);
            end
        end
    endtask

    task automatic test_range();
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            for (int t = 0; t < 2; t++) begin
                drive(t == 0 ? 7'h7F : 7'h00, t == 0, 7'h35, 2'(m), 1'b1, 1'b0);
                @(posedge clk); #1;
                e = exp_q.pop_front();
                last_e = e;
                checks++;
                if (y !== '0 || y_c !== (t == 0) || out_valid !== 1'b1 ||
                    y !== e.y || y_c !== e.yc) begin
                    errors++;
                    $display("FAIL range m%0d t%0d y=%b y_c=%b want 0 %b",
                             m, t, y, y_c, t == 0);
                end
            end
        end
    endtask

    task automatic test_binary();
        exp_t e;
        drive(7'h55, 1'b0, 7'h00, 2'b10, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        last_e = e;
        checks++;
        if (y !== 14'b01_00_01_00_01_00_01 || y_c !== 1'b0 || dut.q !== '0 ||
            y !== e.y) begin
            errors++;
            $display("FAIL binary y=%b y_c=%b q=%h want 01000100010001 0 0",
                     y, y_c, dut.q);
        end
    endtask

    task automatic test_clr();
        exp_t e;
        drive(7'h00, 1'b0, 7'h00, 2'b00, 1'b0, 1'b1);
        drive(7'h01, 1'b0, 7'h7F, 2'b00, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        last_e = e;
        checks++;
        if (dut.q[1:0] !== 2'b01 || y !== e.y) begin
            errors++;
            $display("FAIL clr_setup q0=%b y=%b want 01 %b", dut.q[1:0], y, e.y);
        end
        drive(7'h01, 1'b0, 7'h00, 2'b00, 1'b1, 1'b1);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        last_e = e;
        checks++;
        if (y[1:0] !== 2'b10 || dut.q !== '0 || y !== e.y || y_c !== e.yc ||
            out_valid !== 1'b1 || decode(y, y_c) != 1) begin
            errors++;
            $display("FAIL clr_en y=%b y_c=%b q=%h want %b %b 0",
                     y, y_c, dut.q, e.y, e.yc);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(7'h00, 1'b0, 7'h00, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(7'h01, 1'b0, 7'h7F, 2'b00, 1'b1, 1'b0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            last_e = e;
        end
        drive(7'h01, 1'b0, 7'h7F, 2'b00, 1'b1, 1'b0);
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if (y !== '0 || y_c !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid y=%h y_c=%b ov=%b want 0 0 0", y, y_c, out_valid);
        end
        model_reset();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        drive(7'h01, 1'b0, 7'h7F, 2'b00, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        last_e = e;
        checks++;
        if (y[1:0] !== 2'b01 || y !== e.y || y_c !== e.yc || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first y=%b y_c=%b ov=%b want %b %b 1",
                     y, y_c, out_valid, e.y, e.yc);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   bad = 0;
        int   want;
        logic [N-1:0] xv;
        logic xcv, env, clrv;
        for (int i = 0; i < 10000; i++) begin
            xv   = N'($urandom);
            xcv  = 1'($urandom);
            env  = ($urandom_range(0, 7) != 0);
            clrv = ($urandom_range(0, 31) == 0);
            drive(xv, xcv, N'($urandom), 2'($urandom), env, clrv);
            want = int'(xv) + int'(xcv);
            @(posedge clk); #1;
            if (env) begin
                e = exp_q.pop_front();
                last_e = e;
                checks++;
                if (y !== e.y || y_c !== e.yc || out_valid !== 1'b1 ||
                    decode(y, y_c) != want) begin
                    errors++;
                    $display("FAIL rand[%0d] y=%b y_c=%b sum=%0d want %b %b %0d",
                             i, y, y_c, decode(y, y_c), e.y, e.yc, want);
                end
            end else begin
                checks++;
                if (y !== last_e.y || y_c !== last_e.yc || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_hold[%0d] y=%b ov=%b want %b 0",
                             i, y, out_valid, last_e.y);
                end
            end
            if (q_bad() || dut.q !== q_enc()) bad++;
        end
        checks++;
        if (bad != 0 || dut.lfsr !== lfsr_m) begin
            errors++;
            $display("FAIL rand_state qbad=%0d lfsr=%h want 0 %h", bad, dut.lfsr, lfsr_m);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_shape();
        test_hold();
        test_range();
        test_binary();
        test_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
